// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, LCD command constants and init ROM for the LCD bus sequencer
package lcd_pkg;

  localparam int TICK_W = 8;

  typedef enum logic [2:0] {
    PWR_WAIT,
    LOAD,
    SETUP,
    E_HIGH,
    HOLD,
    EXEC_WAIT,
    IDLE
  } state_t;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_ENTRY      = 8'h06;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_DDRAM_BASE = 8'h80;

  localparam int INIT_LEN = 6;
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);
  localparam logic [0:INIT_LEN-1][7:0] INIT_ROM = {
    CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY
  };

  // Clear (0x01) and the two home encodings (0x02, 0x03) need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] db);
    return !rs && (db == CMD_CLEAR || db == CMD_HOME || db == (CMD_CLEAR | CMD_HOME));
  endfunction

  function automatic logic [7:0] ddram_cmd(input logic [6:0] addr);
    return CMD_DDRAM_BASE | {1'b0, addr};
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// rtl/lcd_phase_timer.sv - counts tick strobes within one sequencer phase and flags the last one
module lcd_phase_timer
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              clear,
  input  logic [TICK_W-1:0] length,
  output logic              expire
);

  logic [TICK_W-1:0] count;

  // A tick in the clearing (entry) cycle is neither counted nor allowed to expire the phase.
  assign expire = tick && !clear && (count == length - TICK_W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// rtl/lcd_bus_sequencer.sv - HD44780 bus write sequencer: power-on init, then single-byte writes
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERON_TICKS = 20,
  parameter int SETUP_TICKS   = 1,
  parameter int E_HIGH_TICKS  = 1,
  parameter int HOLD_TICKS    = 1,
  parameter int EXEC_TICKS    = 1,
  parameter int CLEAR_TICKS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic       E_out,
  output logic       RW_out,
  output logic       RS_out,
  output logic [7:0] DB_out
);

  state_t            state, state_next;
  logic              phase_entry;
  logic              expire;
  logic [2:0]        init_idx, init_idx_next;
  logic              done_next;
  logic              rs_next;
  logic [7:0]        db_next;
  logic [TICK_W-1:0] phase_len;

  lcd_phase_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .clear  (phase_entry),
    .length (phase_len),
    .expire (expire)
  );

  always_comb begin
    state_next    = state;
    init_idx_next = init_idx;
    done_next     = init_done;
    rs_next       = RS_out;
    db_next       = DB_out;
    phase_len     = TICK_W'(EXEC_TICKS);
    case (state)
      PWR_WAIT: begin
        phase_len = TICK_W'(POWERON_TICKS);
        if (expire) begin
          state_next    = LOAD;
          init_idx_next = '0;
          rs_next       = 1'b0;
          db_next       = INIT_ROM[0];
        end
      end
      LOAD: state_next = SETUP;
      SETUP: begin
        phase_len = TICK_W'(SETUP_TICKS);
        if (expire) state_next = E_HIGH;
      end
      E_HIGH: begin
        phase_len = TICK_W'(E_HIGH_TICKS);
        if (expire) state_next = HOLD;
      end
      HOLD: begin
        phase_len = TICK_W'(HOLD_TICKS);
        if (expire) state_next = EXEC_WAIT;
      end
      EXEC_WAIT: begin
        phase_len = is_slow_cmd(RS_out, DB_out) ? TICK_W'(CLEAR_TICKS) : TICK_W'(EXEC_TICKS);
        if (expire) begin
          if (!init_done && init_idx != INIT_LAST) begin
            init_idx_next = init_idx + 3'd1;
            state_next    = LOAD;
            rs_next       = 1'b0;
            db_next       = INIT_ROM[init_idx_next];
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      IDLE: begin
        // The RS/DB registers double as the request latch; they load on the transfer edge.
        if (req_valid && req_ready) begin
          state_next = LOAD;
          rs_next    = req_rs;
          db_next    = req_data;
        end
      end
      default: state_next = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PWR_WAIT;
      phase_entry <= 1'b1;
      init_idx    <= '0;
      init_done   <= 1'b0;
      E_out       <= 1'b0;
      RW_out      <= 1'b0;
      RS_out      <= 1'b0;
      DB_out      <= 8'h00;
      req_ready   <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_next;
      phase_entry <= (state_next != state);
      init_idx    <= init_idx_next;
      init_done   <= done_next;
      E_out       <= (state_next == E_HIGH);
      RW_out      <= 1'b0;
      RS_out      <= rs_next;
      DB_out      <= db_next;
      req_ready   <= (state_next == IDLE);
      busy        <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb/tb_lcd_bus_sequencer.sv - self-checking bench for lcd_bus_sequencer against a pulse-level model
module tb_lcd_bus_sequencer;

  localparam int POWERON = 3;
  localparam int CLEAR   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, busy, E_out, RW_out, RS_out;
  logic [7:0] DB_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] rom_exp [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_bus_sequencer #(
    .POWERON_TICKS (POWERON),
    .SETUP_TICKS   (1),
    .E_HIGH_TICKS  (1),
    .HOLD_TICKS    (1),
    .EXEC_TICKS    (1),
    .CLEAR_TICKS   (CLEAR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_done (init_done),
    .busy      (busy),
    .E_out     (E_out),
    .RW_out    (RW_out),
    .RS_out    (RS_out),
    .DB_out    (DB_out)
  );

  always #5 clk = ~clk;

  int tcnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      tick = (tcnt % 4 == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // Pulse-level monitor: every E pulse with its byte, ticks while E high, ticks since previous fall.
  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         gap;
    int         hi;
  } pulse_t;

  pulse_t     pulses[$];
  int         gap_ticks = 0, e_ticks = 0, ready_gap = -1;
  int         rw_err = 0, stab_err = 0, cyc = 0;
  int         done_rise_cyc = -1, ready_rise_cyc = -1;
  logic       e_prev = 0, ready_prev = 0, done_prev = 0, first_cycle = 1, hold_chk = 0;
  logic       cap_rs = 0;
  logic [7:0] cap_db = 0;

  always @(negedge clk) begin
    pulse_t p;
    cyc++;
    if (reset) begin
      pulses.delete();
      gap_ticks = 0; e_ticks = 0; ready_gap = -1;
      e_prev = 0; ready_prev = 0; done_prev = 0; first_cycle = 1; hold_chk = 0;
      done_rise_cyc = -1; ready_rise_cyc = -1;
    end else begin
      if (RW_out !== 1'b0) rw_err++;
      if (E_out && !e_prev) begin
        p.rs = RS_out; p.db = DB_out; p.gap = gap_ticks; p.hi = 0;
        pulses.push_back(p);
        cap_rs = RS_out; cap_db = DB_out; e_ticks = 0;
      end
      if (!E_out && e_prev) begin
        if (pulses.size() > 0) pulses[pulses.size()-1].hi = e_ticks;
        gap_ticks = 0; hold_chk = 1;
      end
      if ((E_out || hold_chk) && (RS_out !== cap_rs || DB_out !== cap_db)) stab_err++;
      if (req_ready && !ready_prev) begin
        ready_gap = gap_ticks;
        if (ready_rise_cyc < 0) ready_rise_cyc = cyc;
      end
      if (init_done && !done_prev) done_rise_cyc = cyc;
      if (tick && !first_cycle) begin
        if (E_out) e_ticks++;
        else begin
          gap_ticks++;
          hold_chk = 0;
        end
      end
      first_cycle = 0; e_prev = E_out; ready_prev = req_ready; done_prev = init_done;
    end
  end

  function automatic int exp_exec(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLEAR : 1;
  endfunction

  task automatic wait_ready(input int limit, output bit ok);
    int n = 0;
    ok = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (req_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input bit keep, output bit ok);
    int n = 0;
    req_valid = 1; req_rs = rs; req_data = d;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready === 1'b1);
    @(negedge clk);
    if (!keep) req_valid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; req_valid = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({E_out, RW_out, RS_out, DB_out} !== 11'h000) begin
      failures++;
      $display("FAIL reset_pins: E/RW/RS/DB got %b%b%b %h want 000 00", E_out, RW_out, RS_out, DB_out);
    end
    checks++;
    if ({req_ready, init_done, busy} !== 3'b001) begin
      failures++;
      $display("FAIL reset_status: ready/done/busy got %b%b%b want 001", req_ready, init_done, busy);
    end
    @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_power_on();
    int n = 0;
    int exp_gap;
    req_valid = 1; req_rs = 1; req_data = 8'($urandom_range(0, 255));
    while (init_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    req_valid = 0;
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_timeout: init_done=%b after %0d cycles want 1", init_done, n);
    end
    checks++;
    if (pulses.size() != 6) begin
      failures++;
      $display("FAIL init_count: got %0d pulses want 6", pulses.size());
    end
    for (int i = 0; i < pulses.size() && i < 6; i++) begin
      checks++;
      if (pulses[i].rs !== 1'b0 || pulses[i].db !== rom_exp[i]) begin
        failures++;
        $display("FAIL init_byte[%0d]: got rs=%b db=%h want rs=0 db=%h", i, pulses[i].rs, pulses[i].db, rom_exp[i]);
      end
      if (i == 0) exp_gap = POWERON + 1;
      else exp_gap = 2 + exp_exec(1'b0, rom_exp[i-1]);
      checks++;
      if (pulses[i].hi != 1 || pulses[i].gap != exp_gap) begin
        failures++;
        $display("FAIL init_timing[%0d]: got hi=%0d gap=%0d want hi=1 gap=%0d", i, pulses[i].hi, pulses[i].gap, exp_gap);
      end
    end
    checks++;
    if (ready_gap != 2) begin
      failures++;
      $display("FAIL init_last_wait: got %0d ticks want 2", ready_gap);
    end
    checks++;
    if (ready_rise_cyc < 0 || ready_rise_cyc != done_rise_cyc) begin
      failures++;
      $display("FAIL init_ready_together: ready rose cyc %0d done rose cyc %0d want equal", ready_rise_cyc, done_rise_cyc);
    end
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL init_idle: ready/busy got %b%b want 10", req_ready, busy);
    end
  endtask

  task automatic test_data_write();
    int tk = 0, c = 0;
    bit ok;
    wait_ready(200, ok);
    pulses.delete();
    req_valid = 1; req_rs = 1; req_data = 8'h35;
    @(negedge clk);
    req_valid = 0;
    checks++;
    if ({req_ready, busy, E_out} !== 3'b010) begin
      failures++;
      $display("FAIL write_accept: ready/busy/E got %b%b%b want 010", req_ready, busy, E_out);
    end
    checks++;
    if (RS_out !== 1'b1 || DB_out !== 8'h35) begin
      failures++;
      $display("FAIL write_load: got rs=%b db=%h want rs=1 db=35", RS_out, DB_out);
    end
    // Skip the LOAD cycle and the SETUP entry cycle, then count ticks until idle.
    while (req_ready !== 1'b1 && c < 200) begin
      if (c >= 2 && tick) tk++;
      c++;
      @(negedge clk);
    end
    checks++;
    if (tk != 4) begin
      failures++;
      $display("FAIL write_duration: got %0d ticks want 4", tk);
    end
    @(negedge clk);
    checks++;
    if (pulses.size() != 1 || pulses[0].rs !== 1'b1 || pulses[0].db !== 8'h35 || pulses[0].hi != 1) begin
      failures++;
      $display("FAIL write_pulse: got %0d pulses want one rs=1 db=35 hi=1", pulses.size());
    end
  endtask

  task automatic test_random_writes();
    bit ok, ok2;
    for (int k = 0; k < 10; k++) begin
      logic       rs;
      logic [7:0] d;
      int         idle;
      rs = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 9) < 4) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      idle = $urandom_range(0, 5);
      repeat (idle) @(negedge clk);
      pulses.delete();
      send(rs, d, 0, ok);
      wait_ready(200, ok2);
      checks++;
      if (!ok || !ok2 || pulses.size() != 1 || pulses[0].rs !== rs || pulses[0].db !== d || pulses[0].hi != 1) begin
        failures++;
        $display("FAIL rand_pulse[%0d]: got %0d pulses want one rs=%b db=%h hi=1", k, pulses.size(), rs, d);
      end
      checks++;
      if (ready_gap != 1 + exp_exec(rs, d)) begin
        failures++;
        $display("FAIL rand_exec[%0d]: rs=%b db=%h got %0d ticks want %0d", k, rs, d, ready_gap, 1 + exp_exec(rs, d));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    pulses.delete();
    send(1'b0, 8'h80, 1, ok1);
    send(1'b1, 8'h31, 0, ok2);
    wait_ready(200, ok3);
    checks++;
    if (!ok1 || !ok2 || !ok3 || pulses.size() != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d pulses want 2", pulses.size());
    end else begin
      checks++;
      if (pulses[0].rs !== 1'b0 || pulses[0].db !== 8'h80 || pulses[1].rs !== 1'b1 || pulses[1].db !== 8'h31) begin
        failures++;
        $display("FAIL b2b_order: got %b/%h %b/%h want 0/80 1/31", pulses[0].rs, pulses[0].db, pulses[1].rs, pulses[1].db);
      end
    end
    checks++;
    if (rw_err != 0 || stab_err != 0) begin
      failures++;
      $display("FAIL bus_rules: got rw_err=%0d stab_err=%0d want 0 0", rw_err, stab_err);
    end
  endtask

  task automatic test_clear_timing();
    bit ok1, ok2;
    send(1'b0, 8'h01, 0, ok1);
    wait_ready(200, ok2);
    checks++;
    if (!ok1 || !ok2 || ready_gap != 1 + CLEAR) begin
      failures++;
      $display("FAIL clear_exec: got %0d ticks want %0d", ready_gap, 1 + CLEAR);
    end
    send(1'b0, 8'hC0, 0, ok1);
    wait_ready(200, ok2);
    checks++;
    if (!ok1 || !ok2 || ready_gap != 2) begin
      failures++;
      $display("FAIL normal_exec: got %0d ticks want 2", ready_gap);
    end
  endtask

  task automatic test_tick_on_accept();
    int n = 0, tk = 0, c = 0;
    bit ok;
    while (!(req_ready === 1'b1 && tick === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1; req_rs = 1; req_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    req_valid = 0;
    while (E_out !== 1'b1 && c < 50) begin
      if (tick) tk++;
      c++;
      @(negedge clk);
    end
    checks++;
    if (tk != 1 || c != 4) begin
      failures++;
      $display("FAIL accept_tick: got %0d ticks in %0d cycles before E want 1 in 4", tk, c);
    end
    wait_ready(200, ok);
    checks++;
    if (!ok || ready_gap != 2) begin
      failures++;
      $display("FAIL accept_tick_exec: got %0d ticks want 2", ready_gap);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n = 0;
    bit ok;
    send(1'b1, 8'h41, 0, ok);
    while (E_out !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (E_out !== 1'b1) begin
      failures++;
      $display("FAIL midpulse_e: E never rose, got %b want 1", E_out);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({E_out, RS_out, DB_out, init_done, req_ready, busy} !== 13'b0_0_00000000_0_0_1) begin
      failures++;
      $display("FAIL midpulse_reset: E/RS/DB/done/ready/busy got %b %b %h %b %b %b want 0 0 00 0 0 1",
               E_out, RS_out, DB_out, init_done, req_ready, busy);
    end
    @(posedge clk);
    #1 reset = 0;
    test_power_on();
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_data_write();
    test_random_writes();
    test_back_to_back();
    test_clear_timing();
    test_tick_on_accept();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
- Owns the HD44780-style LCD pins (E/RW/RS/DB) and serialises every bus write with correct E-pulse framing.
- Paced by a 1 ms tick strobe, runs the power-on init sequence automatically, then accepts single command/data bytes from upstream over a valid/ready handshake.
- Sits between the display-content logic (digit formatting, cursor addressing) and the LCD pins, replacing ad-hoc sequencing.
- Runs on the system clock; the divided 1 ms signal is used as an enable, never as a clock.

Parameters:
- POWERON_TICKS, 20, ticks waited after reset before the first init write.
- SETUP_TICKS, 1, ticks RS/DB are stable before E rises.
- E_HIGH_TICKS, 1, ticks E is held high.
- HOLD_TICKS, 1, ticks RS/DB are held after E falls.
- EXEC_TICKS, 1, post-write execution wait for ordinary writes.
- CLEAR_TICKS, 2, post-write execution wait for clear/home (RS=0, data 0x01, 0x02 or 0x03).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide 1 ms strobe.
- req_valid  in  1  upstream write request.
- req_rs  in  1  0 = command, 1 = data.
- req_data  in  8  byte to write.
- req_ready  out  1  block can accept a request this cycle.
- init_done  out  1  init sequence complete; sticky until reset.
- busy  out  1  state != IDLE.
- E_out  out  1  LCD enable.
- RW_out  out  1  LCD read/write; constant 0 (write-only).
- RS_out  out  1  LCD register select.
- DB_out  out  8  LCD data bus.

Behaviour:
- Interface: single clock `clk`; `reset` is synchronous, active-high.
- All outputs are registered.
- Reset values: E_out=0, RW_out=0, RS_out=0, DB_out=0x00, req_ready=0, init_done=0, busy=1. State after reset is PWR_WAIT.
- Reset asserted at any point (mid-pulse included) drops E_out to 0 on the next edge and restarts power-on from PWR_WAIT. Reset wins over tick and req_valid.
- Phase timer:
  - On entering a timed state the counter clears.
  - A tick in the entry cycle is not counted.
  - Each later tick increments the counter.
  - When tick=1 and count == N-1 the state advances on that edge, so a state lasts exactly N ticks.
  - All tick parameters are at least 1; counter width is 8 bits.
- States:
  - PWR_WAIT: POWERON_TICKS, then LOAD with init index 0.
  - LOAD: one clk; drives RS/DB from the init ROM (RS=0) or from the request latch; goes to SETUP.
  - SETUP: E=0 for SETUP_TICKS, then E_HIGH.
  - E_HIGH: E=1 for E_HIGH_TICKS, then HOLD; E falls on the exit edge.
  - HOLD: E=0 with RS/DB unchanged for HOLD_TICKS, then EXEC_WAIT.
  - EXEC_WAIT: CLEAR_TICKS if the byte is clear/home with RS=0, otherwise EXEC_TICKS. On exit:
    - during init with index < 5: index+1, back to LOAD;
    - during init with index == 5: init_done=1, go to IDLE;
    - otherwise: IDLE.
  - IDLE: req_ready=1, E=0, RS/DB hold the last written values.
- Init ROM, in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- Handshake:
  - Transfer happens when req_valid && req_ready (IDLE only); it needs no tick.
  - On transfer, req_rs/req_data are latched, and the next cycle is LOAD with req_ready=0 and busy=1.
  - req_ready is 0 in every state except IDLE.
  - req_valid while not ready is ignored. Upstream holds valid and data stable until the transfer; no queueing.
- DB_out/RS_out change only in LOAD. They never change while E_out=1 or during HOLD.

Decomposition:
- Package lcd_pkg holds:
  - state enum;
  - LCD command constants: CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06, CMD_HOME=0x02, CMD_DDRAM_BASE=0x80;
  - init ROM array and INIT_LEN=6;
  - TICK_W=8.
- One sub-module, lcd_phase_timer: tick counter with clear/load-N/expire outputs, instantiated once.

Test Plan:
- Bench parameters: tick every 4 clk; POWERON_TICKS=3, CLEAR_TICKS=2, all others 1.
- Power-on: release reset -> exactly 3 ticks, then 6 E pulses carrying DB=0x38,0x38,0x38,0x0C,0x01,0x06 with RS=0; each E high for exactly 1 tick; 2-tick wait after 0x01; init_done and req_ready rise together after the 0x06 wait.
- Data write: after init, req_valid=1, req_rs=1, req_data=0x35 -> req_ready=0 next clk; RS=1/DB=0x35 set in LOAD before E rises; one E pulse; idle again after 4 ticks.
- Backpressure: req_valid held with 0x80 then 0x31 issued back-to-back -> exactly two pulses in order; RW_out=0 throughout; no byte lost or duplicated; req_valid during init is never accepted.
- Clear timing: command 0x01 -> EXEC_WAIT lasts 2 ticks versus 1 tick for 0xC0.
- Reset mid-pulse: assert reset while E_out=1 -> next edge E_out=0, DB=0x00, init_done=0; full init replays.
- Tick on accept cycle: tick coincident with the transfer edge is not counted; SETUP still lasts 1 full later tick.
